qspi_sram_emu: RTL and testbench

Parametrised, clk-synchronous QSPI SRAM emulator for the simulation top and FPGA bring-up harness; next generation of the sck-clocked QSPI SRAM model. It oversamples `sck` with the system clock, serves `NUM_CS` independent banks on one shared SIO bus, and supports SPI and QPI modes with configurable fast-read dummy cycles. It sits between the DUT's `uio_out`/`uio_oe` pins and `uio_in`, in place of the PMOD SRAM.

---
 rtl/qspi_sram_emu_pkg.sv | 35 +++
 rtl/qspi_sram_emu_mem.sv | 29 ++
 rtl/qspi_sram_emu.sv | 242 ++++++++++++++++++++++++
 tb/tb_qspi_sram_emu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_sram_emu_pkg.sv
// Shared opcodes, FSM state encoding and serial address width for the
// clk-oversampled QSPI SRAM emulator.
package qspi_sram_emu_pkg;

    localparam int SPI_ADDR_W = 24;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_ENTER_QPI = 8'h35;
    localparam logic [7:0] CMD_EXIT_QPI  = 8'hF5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_e;

    // Shift one serial beat into a byte: 1 bit on sio[0] (SPI) or a nibble (QPI).
    function automatic logic [7:0] shift_byte(input logic [7:0] cur, input logic [3:0] sio,
                                              input logic qpi);
        logic [7:0] res;
        if (qpi) begin
            res = {cur[3:0], sio};
        end else begin
            res = {cur[6:0], sio[0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/qspi_sram_emu_mem.sv
// Byte storage for all banks: one synchronous write port, one asynchronous
// read port, contents survive reset.
module qspi_sram_emu_mem #(
    parameter int NUM_CS = 1,
    parameter int ADDR_W = 16,
    parameter int BANK_W = 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [BANK_W-1:0] wbank_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [BANK_W-1:0] rbank_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [NUM_CS][2**ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule

// File: rtl/qspi_sram_emu.sv
// Multi-bank QSPI SRAM emulator oversampling sck with clk; SPI/QPI per bank.
// Define QSPI_SRAM_EMU_ERR_EN to add the sticky protocol-error output err.
module qspi_sram_emu
    import qspi_sram_emu_pkg::*;
#(
    parameter int NUM_CS       = 1,
    parameter int ADDR_W       = 16,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic [NUM_CS-1:0] ss_n,
    input  logic [3:0]        sio_in,
    output logic [3:0]        sio_out,
    output logic [3:0]        sio_oe
`ifdef QSPI_SRAM_EMU_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int BANK_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    state_e            state_q;
    logic              sck_q;
    logic [NUM_CS-1:0] ss_n_q;
    logic [BANK_W-1:0] bank_q;
    logic [NUM_CS-1:0] qpi_q;
    logic              mode_pend_q;
    logic              mode_val_q;
    logic [7:0]        opc_q;
    logic [7:0]        sh_q;
    logic [23:0]       addr_q;
    logic [4:0]        cnt_q;
    logic [15:0]       dcnt_q;
    logic [3:0]        sio_out_q;
    logic [3:0]        sio_oe_q;
`ifdef QSPI_SRAM_EMU_ERR_EN
    logic              err_q;
`endif

    logic              rise_s, fall_s, desel_s, none_s, multi_s, abort_s, qpi_s, we_s;
    logic [2:0]        sel_cnt_s;
    logic [BANK_W-1:0] sel_idx_s;
    logic [4:0]        cnt_d;
    logic [7:0]        sh_d;
    logic [23:0]       addr_d;
    logic [7:0]        rbyte_s;
    logic [7:0]        mem_rdata_s;

    // Bank decode: count asserted selects and remember the selected index
    always_comb begin
        sel_cnt_s = 3'd0;
        sel_idx_s = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            sel_cnt_s = sel_cnt_s + {2'b00, ~ss_n[i]};
            if (!ss_n[i]) begin
                sel_idx_s = BANK_W'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // Edge detect, abort conditions and serial shift next-values
    always_comb begin
        rise_s  = sck & ~sck_q;
        fall_s  = ~sck & sck_q;
        desel_s = |(ss_n & ~ss_n_q);
        none_s  = &ss_n;
        multi_s = (sel_cnt_s > 3'd1);
        abort_s = desel_s | none_s | multi_s;
        qpi_s   = qpi_q[bank_q];
        cnt_d   = cnt_q + (qpi_s ? 5'd4 : 5'd1);
        sh_d    = shift_byte(sh_q, sio_in, qpi_s);
        if (qpi_s) begin
            addr_d = {addr_q[19:0], sio_in};
        end else begin
            addr_d = {addr_q[22:0], sio_in[0]};
        end
        rbyte_s = (cnt_q == 5'd0) ? mem_rdata_s : sh_q;
        we_s    = (state_q == ST_WDATA) && rise_s && !abort_s && (cnt_d == 5'd8);
    end

    qspi_sram_emu_mem #(
        .NUM_CS (NUM_CS),
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (we_s),
        .wbank_i (bank_q),
        .waddr_i (addr_q[ADDR_W-1:0]),
        .wdata_i (sh_d),
        .rbank_i (bank_q),
        .raddr_i (addr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata_s)
    );

    // Protocol FSM with registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sck_q       <= 1'b0;
            ss_n_q      <= '1;
            bank_q      <= '0;
            qpi_q       <= '0;
            mode_pend_q <= 1'b0;
            mode_val_q  <= 1'b0;
            opc_q       <= 8'h00;
            sh_q        <= 8'h00;
            addr_q      <= 24'h000000;
            cnt_q       <= 5'd0;
            dcnt_q      <= 16'd0;
            sio_out_q   <= 4'h0;
            sio_oe_q    <= 4'h0;
`ifdef QSPI_SRAM_EMU_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            sck_q  <= sck;
            ss_n_q <= ss_n;
            if (abort_s) begin
                // Deselect beats any same-cycle sck edge; partial bytes are dropped
                sio_oe_q  <= 4'h0;
                sio_out_q <= 4'h0;
                cnt_q     <= 5'd0;
                if (mode_pend_q && (desel_s || none_s)) begin
                    qpi_q[bank_q] <= mode_val_q;
                    mode_pend_q   <= 1'b0;
                end
`ifdef QSPI_SRAM_EMU_ERR_EN
                if (multi_s || (((state_q == ST_CMD) || (state_q == ST_ADDR) ||
                                 (state_q == ST_WDATA)) && (cnt_q[2:0] != 3'd0))) begin
                    err_q <= 1'b1;
                end
`endif
                // A multi-select keeps absorbing until every select is released
                if (multi_s || ((state_q == ST_IGNORE) && !none_s)) begin
                    state_q <= ST_IGNORE;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        bank_q  <= sel_idx_s;
                        cnt_q   <= 5'd0;
                        state_q <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (rise_s) begin
                            sh_q  <= sh_d;
                            cnt_q <= (cnt_d == 5'd8) ? 5'd0 : cnt_d;
                            if (cnt_d == 5'd8) begin
                                opc_q <= sh_d;
                                case (sh_d)
                                    CMD_READ, CMD_FAST_READ, CMD_WRITE: state_q <= ST_ADDR;
                                    CMD_ENTER_QPI: begin
                                        mode_pend_q <= 1'b1;
                                        mode_val_q  <= 1'b1;
                                        state_q     <= ST_IGNORE;
                                    end
                                    CMD_EXIT_QPI: begin
                                        mode_pend_q <= 1'b1;
                                        mode_val_q  <= 1'b0;
                                        state_q     <= ST_IGNORE;
                                    end
                                    default: begin
`ifdef QSPI_SRAM_EMU_ERR_EN
                                        err_q <= 1'b1;
`endif
                                        state_q <= ST_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise_s) begin
                            addr_q <= addr_d;
                            cnt_q  <= cnt_d;
                            dcnt_q <= 16'd0;
                            if (cnt_d == 5'(SPI_ADDR_W)) begin
                                cnt_q <= 5'd0;
                                case (opc_q)
                                    CMD_WRITE:     state_q <= ST_WDATA;
                                    CMD_FAST_READ: state_q <= (DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY;
                                    default:       state_q <= ST_RDATA;
                                endcase
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (rise_s) begin
                            dcnt_q <= dcnt_q + 16'd1;
                            if ((dcnt_q + 16'd1) == 16'(DUMMY_CYCLES)) begin
                                state_q <= ST_RDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        // Fetch a fresh byte at each byte boundary, then shift MSB first
                        if (fall_s) begin
                            sio_oe_q <= qpi_s ? 4'hF : 4'b0010;
                            cnt_q    <= (cnt_d == 5'd8) ? 5'd0 : cnt_d;
                            if (cnt_q == 5'd0) begin
                                addr_q <= addr_q + 24'd1;
                            end
                            if (qpi_s) begin
                                sio_out_q <= rbyte_s[7:4];
                                sh_q      <= {rbyte_s[3:0], 4'h0};
                            end else begin
                                sio_out_q <= {2'b00, rbyte_s[7], 1'b0};
                                sh_q      <= {rbyte_s[6:0], 1'b0};
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rise_s) begin
                            sh_q  <= sh_d;
                            cnt_q <= (cnt_d == 5'd8) ? 5'd0 : cnt_d;
                            if (cnt_d == 5'd8) begin
                                addr_q <= addr_q + 24'd1;
                            end
                        end
                    end
                    ST_IGNORE: state_q <= ST_IGNORE;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign sio_out = sio_out_q;
    assign sio_oe  = sio_oe_q;
`ifdef QSPI_SRAM_EMU_ERR_EN
    assign err     = err_q;
`endif

endmodule

// File: tb/tb_qspi_sram_emu.sv
// Directed self-checking bench for qspi_sram_emu (two banks, 16-bit address, 8 dummy cycles).
module tb_qspi_sram_emu;

    localparam int NUM_CS       = 2;
    localparam int ADDR_W       = 16;
    localparam int DUMMY_CYCLES = 8;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              sck    = 1'b0;
    logic [NUM_CS-1:0] ss_n   = 2'b11;
    logic [3:0]        sio_in = 4'h0;
    logic [3:0]        sio_out;
    logic [3:0]        sio_oe;
`ifdef QSPI_SRAM_EMU_ERR_EN
    logic              err;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    qspi_sram_emu #(
        .NUM_CS       (NUM_CS),
        .ADDR_W       (ADDR_W),
        .DUMMY_CYCLES (DUMMY_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sck     (sck),
        .ss_n    (ss_n),
        .sio_in  (sio_in),
        .sio_out (sio_out),
`ifdef QSPI_SRAM_EMU_ERR_EN
        .err     (err),
`endif
        .sio_oe  (sio_oe)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One sck period: 2 clk high, 2 clk low
    task automatic pulse();
        sck = 1'b1;
        tick(2);
        sck = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit q);
        if (q) begin
            sio_in = b[7:4];
            pulse();
            sio_in = b[3:0];
            pulse();
        end else begin
            for (int i = 7; i >= 0; i--) begin
                sio_in = {3'b000, b[i]};
                pulse();
            end
        end
        sio_in = 4'h0;
    endtask

    task automatic recv_byte(input bit q, output logic [7:0] b);
        if (q) begin
            b[7:4] = sio_out;
            pulse();
            b[3:0] = sio_out;
            pulse();
        end else begin
            for (int i = 7; i >= 0; i--) begin
                b[i] = sio_out[1];
                pulse();
            end
        end
    endtask

    task automatic select(input int bank);
        logic [1:0] one;
        one  = 2'b01;
        ss_n = ~(one << bank);
        tick(2);
    endtask

    task automatic deselect();
        sio_in = 4'h0;
        ss_n   = 2'b11;
        tick(3);
    endtask

    task automatic start_cmd(input int bank, input logic [7:0] cmd, input logic [23:0] addr,
                             input bit q);
        select(bank);
        send_byte(cmd, q);
        send_byte(addr[23:16], q);
        send_byte(addr[15:8], q);
        send_byte(addr[7:0], q);
    endtask

    task automatic write1(input int bank, input logic [23:0] addr, input logic [7:0] d);
        start_cmd(bank, 8'h02, addr, 1'b0);
        send_byte(d, 1'b0);
        deselect();
    endtask

    task automatic read1(input int bank, input logic [23:0] addr, output logic [7:0] d);
        start_cmd(bank, 8'h03, addr, 1'b0);
        recv_byte(1'b0, d);
        deselect();
    endtask

    logic [7:0] rd;

    initial begin
        tick(3);
        check_eq("rst_sio_oe", {28'd0, sio_oe}, 32'h0);
        check_eq("rst_sio_out", {28'd0, sio_out}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // SPI write A5 3C at 0x10, read back
        start_cmd(0, 8'h02, 24'h000010, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        deselect();
        start_cmd(0, 8'h03, 24'h000010, 1'b0);
        check_eq("spi_rd_oe", {28'd0, sio_oe}, 32'h2);
        recv_byte(1'b0, rd);
        check_eq("spi_rd_b0", {24'd0, rd}, 32'hA5);
        recv_byte(1'b0, rd);
        check_eq("spi_rd_b1", {24'd0, rd}, 32'h3C);
        ss_n = 2'b11;
        tick(1);
        check_eq("spi_desel_oe", {28'd0, sio_oe}, 32'h0);
        tick(2);

        // Enter QPI on bank 0, fast read with dummies, then exit QPI
        select(0);
        send_byte(8'h35, 1'b0);
        deselect();
        start_cmd(0, 8'h0B, 24'h000010, 1'b1);
        repeat (DUMMY_CYCLES) pulse();
        check_eq("qpi_rd_oe", {28'd0, sio_oe}, 32'hF);
        recv_byte(1'b1, rd);
        check_eq("qpi_rd_b0", {24'd0, rd}, 32'hA5);
        recv_byte(1'b1, rd);
        check_eq("qpi_rd_b1", {24'd0, rd}, 32'h3C);
        deselect();
        select(0);
        send_byte(8'hF5, 1'b1);
        deselect();

        // Independent banks
        write1(0, 24'h000000, 8'h11);
        write1(1, 24'h000000, 8'h22);
        read1(0, 24'h000000, rd);
        check_eq("bank0_rd", {24'd0, rd}, 32'h11);
        read1(1, 24'h000000, rd);
        check_eq("bank1_rd", {24'd0, rd}, 32'h22);

        // Address wrap and upper-bit aliasing
        start_cmd(0, 8'h02, 24'h00FFFF, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        deselect();
        read1(0, 24'h000000, rd);
        check_eq("wrap_rd0", {24'd0, rd}, 32'h88);
        read1(0, 24'h01FFFF, rd);
        check_eq("alias_rd", {24'd0, rd}, 32'h77);

        // Unknown opcode followed by multi-select
        select(0);
        send_byte(8'h9F, 1'b0);
        ss_n = 2'b00;
        tick(2);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        check_eq("multi_oe", {28'd0, sio_oe}, 32'h0);
`ifdef QSPI_SRAM_EMU_ERR_EN
        check_eq("multi_err", {31'd0, err}, 32'h1);
`endif
        deselect();
        read1(0, 24'h000010, rd);
        check_eq("multi_mem", {24'd0, rd}, 32'hA5);

        // Partial write byte discarded on deselect
        write1(0, 24'h000021, 8'h5A);
        start_cmd(0, 8'h02, 24'h000020, 1'b0);
        send_byte(8'h12, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sio_in = 4'h1;
            pulse();
        end
        ss_n = 2'b11;
        tick(1);
        check_eq("partial_oe", {28'd0, sio_oe}, 32'h0);
        tick(2);
        read1(0, 24'h000020, rd);
        check_eq("partial_b0", {24'd0, rd}, 32'h12);
        read1(0, 24'h000021, rd);
        check_eq("partial_b1", {24'd0, rd}, 32'h5A);

        // Bank 1 to QPI, then reset in the middle of a bank 0 read
        select(1);
        send_byte(8'h35, 1'b0);
        deselect();
        start_cmd(0, 8'h03, 24'h000010, 1'b0);
        pulse();
        pulse();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_oe", {28'd0, sio_oe}, 32'h0);
        check_eq("rst_mid_out", {28'd0, sio_out}, 32'h0);
        ss_n = 2'b11;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        read1(1, 24'h000000, rd);
        check_eq("rst_bank1_spi", {24'd0, rd}, 32'h22);
        read1(0, 24'h000010, rd);
        check_eq("rst_mem_kept", {24'd0, rd}, 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
